// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath-select encodings shared by the multicycle control unit
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
  } statetype;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus funct3/funct7b5/op[5] onto the 3-bit ALUControl code
// Ports: alu_op_i (ALUOp), funct3_i, funct7b5_i, op5_i (R-type marker) -> alu_control_o
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);
  logic [2:0] funct_ctl;
  // funct7b5 only means subtract for R-type; for I-type it is an immediate bit
  assign funct_ctl = funct3_i == 3'b000 ? ((op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD) :
                     funct3_i == 3'b010 ? ALU_SLT :
                     funct3_i == 3'b110 ? ALU_OR  :
                     funct3_i == 3'b111 ? ALU_AND : ALU_ADD;
  assign alu_control_o = alu_op_i == ALUOP_SUB   ? ALU_SUB :
                         alu_op_i == ALUOP_FUNCT ? funct_ctl : ALU_ADD;
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore control FSM for the multicycle RV32I core
// Inputs: CLK, Reset (sync, active-high), op, funct3, funct7b5, Zero, MemReady (MC_MEM_WAIT_EN only)
// Outputs: IRWrite, PCWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
//          ALUControl, IllegalOp
// Build option: MC_MEM_WAIT_EN adds MemReady handshaking with a MEM_TIMEOUT abort
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
`ifdef MC_MEM_WAIT_EN
  ,
  input  logic       MemReady
`endif
);
  logic [3:0] state_q, state_d, fsm_d;
  logic [1:0] alu_op;
  logic       ir_write, pc_update, branch, mem_write, reg_write, illegal;
  logic       mem_ok, timeout;
`ifdef MC_MEM_WAIT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          wait_st;
  assign wait_st = state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE;
  assign mem_ok  = MemReady;
  assign timeout = wait_st & ~MemReady & (cnt_q == CW'(MEM_TIMEOUT - 1));
  // Every non-memory state leaves after one cycle, so clearing on any state change
  // restarts the count on each entry to a waiting state.
  always_ff @(posedge CLK)
    cnt_q <= (Reset || timeout || state_d != state_q) ? '0 : cnt_q + 1'b1;
`else
  logic unused_cfg;
  assign unused_cfg = MEM_TIMEOUT[0];
  assign mem_ok     = 1'b1;
  assign timeout    = 1'b0;
`endif
  always_comb begin
    fsm_d     = FETCH;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        ir_write  = mem_ok;
        pc_update = mem_ok;
        fsm_d     = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        fsm_d   = (op == OP_LW || op == OP_SW) ? MEMADR :
                  op == OP_R   ? EXECR :
                  op == OP_I   ? EXECI :
                  op == OP_B   ? BEQ   :
                  op == OP_JAL ? JAL   : FETCH;
        illegal = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL});
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        fsm_d   = op == OP_SW ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        fsm_d  = mem_ok ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = mem_ok;
        fsm_d     = mem_ok ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        fsm_d   = ALUWB;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        fsm_d   = ALUWB;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        reg_write = 1'b1;
      end
      default: fsm_d = FETCH;
    endcase
  end
  assign state_d = timeout ? FETCH : fsm_d;
  always_ff @(posedge CLK)
    state_q <= Reset ? FETCH : state_d;
  // funct3[0] distinguishes bne from beq, so it inverts the sense of Zero
  assign PCWrite   = ~Reset & (pc_update | (branch & (Zero ^ funct3[0])));
  assign IRWrite   = ~Reset & ir_write;
  assign MemWrite  = ~Reset & mem_write;
  assign RegWrite  = ~Reset & reg_write;
  assign IllegalOp = ~Reset & (illegal | timeout);
  assign ImmSrc = op == OP_SW  ? IMM_S :
                  op == OP_B   ? IMM_B :
                  op == OP_JAL ? IMM_J : IMM_I;
  alu_decoder u_alu_dec (
    .alu_op_i     (alu_op),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .op5_i        (op[5]),
    .alu_control_o(ALUControl)
  );
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed checks of the multicycle control FSM
module tb_mc_control_fsm;
  logic       CLK = 1'b0, Reset = 1'b1, funct7b5 = 1'b0, Zero = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       IRWrite, PCWrite, AdrSrc, MemWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [4:0] en;
  int checks = 0, errors = 0;
`ifdef MC_MEM_WAIT_EN
  logic MemReady = 1'b1;
`endif
  always #5 CLK = ~CLK;
  mc_control_fsm dut (
    .CLK(CLK), .Reset(Reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .IllegalOp(IllegalOp)
`ifdef MC_MEM_WAIT_EN
    , .MemReady(MemReady)
`endif
  );
  assign en = {IRWrite, PCWrite, MemWrite, RegWrite, IllegalOp};
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    #1;
  endtask
  task automatic fetch_decode(input string tag);
    chk({tag, " fetch en"}, 8'(en), 8'b11000);
    chk({tag, " fetch adr"}, 8'(AdrSrc), 8'd0);
    chk({tag, " fetch srca"}, 8'(ALUSrcA), 8'b00);
    chk({tag, " fetch srcb"}, 8'(ALUSrcB), 8'b10);
    chk({tag, " fetch res"}, 8'(ResultSrc), 8'b10);
    chk({tag, " fetch alu"}, 8'(ALUControl), 8'b000);
    step;
    chk({tag, " decode en"}, 8'(en), 8'b00000);
    chk({tag, " decode srca"}, 8'(ALUSrcA), 8'b01);
    chk({tag, " decode srcb"}, 8'(ALUSrcB), 8'b01);
    chk({tag, " decode alu"}, 8'(ALUControl), 8'b000);
    step;
  endtask
  logic [6:0] t_op [8] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                           7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
  logic [2:0] t_f3 [8] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b000, 3'b111};
  logic       t_f7 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] t_ac [8] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000, 3'b000, 3'b010};
  logic [1:0] t_sb [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
  logic [6:0] t_ill [2] = '{7'b1111111, 7'b0110111};
  initial begin
    repeat (2) step;
    chk("reset en", 8'(en), 8'b00000);
    Reset = 1'b0;
    #1;
    set_instr(7'b0000011, 3'b010, 1'b0);
    chk("lw imm", 8'(ImmSrc), 8'b00);
    fetch_decode("lw");
    chk("lw memadr en", 8'(en), 8'b00000);
    chk("lw memadr srca", 8'(ALUSrcA), 8'b10);
    chk("lw memadr srcb", 8'(ALUSrcB), 8'b01);
    chk("lw memadr alu", 8'(ALUControl), 8'b000);
    step;
    chk("lw memread en", 8'(en), 8'b00000);
    chk("lw memread res", 8'(ResultSrc), 8'b00);
    chk("lw memread adr", 8'(AdrSrc), 8'd1);
    step;
    chk("lw memwb en", 8'(en), 8'b00010);
    chk("lw memwb res", 8'(ResultSrc), 8'b01);
    step;
    set_instr(7'b0100011, 3'b010, 1'b0);
    chk("sw imm", 8'(ImmSrc), 8'b01);
    fetch_decode("sw");
    chk("sw memadr en", 8'(en), 8'b00000);
    chk("sw memadr srca", 8'(ALUSrcA), 8'b10);
    step;
    chk("sw memwrite en", 8'(en), 8'b00100);
    chk("sw memwrite adr", 8'(AdrSrc), 8'd1);
    chk("sw memwrite res", 8'(ResultSrc), 8'b00);
    step;
    for (int i = 0; i < 8; i++) begin
      set_instr(t_op[i], t_f3[i], t_f7[i]);
      fetch_decode($sformatf("alu%0d", i));
      chk($sformatf("alu%0d exec en", i), 8'(en), 8'b00000);
      chk($sformatf("alu%0d exec srca", i), 8'(ALUSrcA), 8'b10);
      chk($sformatf("alu%0d exec srcb", i), 8'(ALUSrcB), 8'(t_sb[i]));
      chk($sformatf("alu%0d exec ctl", i), 8'(ALUControl), 8'(t_ac[i]));
      step;
      chk($sformatf("alu%0d wb en", i), 8'(en), 8'b00010);
      chk($sformatf("alu%0d wb res", i), 8'(ResultSrc), 8'b00);
      step;
    end
    set_instr(7'b1100011, 3'b000, 1'b0);
    Zero = 1'b1;
    #1;
    chk("beq imm", 8'(ImmSrc), 8'b10);
    fetch_decode("beq");
    chk("beq srca", 8'(ALUSrcA), 8'b10);
    chk("beq srcb", 8'(ALUSrcB), 8'b00);
    chk("beq alu", 8'(ALUControl), 8'b001);
    chk("beq res", 8'(ResultSrc), 8'b00);
    chk("beq zero1 en", 8'(en), 8'b01000);
    Zero = 1'b0;
    #1;
    chk("beq zero0 en", 8'(en), 8'b00000);
    step;
    set_instr(7'b1100011, 3'b001, 1'b0);
    fetch_decode("bne");
    chk("bne zero0 en", 8'(en), 8'b01000);
    Zero = 1'b1;
    #1;
    chk("bne zero1 en", 8'(en), 8'b00000);
    step;
    set_instr(7'b1101111, 3'b000, 1'b0);
    chk("jal imm", 8'(ImmSrc), 8'b11);
    fetch_decode("jal");
    chk("jal en", 8'(en), 8'b01010);
    chk("jal srca", 8'(ALUSrcA), 8'b01);
    chk("jal srcb", 8'(ALUSrcB), 8'b10);
    chk("jal res", 8'(ResultSrc), 8'b00);
    step;
    for (int i = 0; i < 2; i++) begin
      set_instr(t_ill[i], 3'b000, 1'b0);
      chk($sformatf("ill%0d fetch en", i), 8'(en), 8'b11000);
      step;
      chk($sformatf("ill%0d decode en", i), 8'(en), 8'b00001);
      step;
    end
    chk("ill after en", 8'(en), 8'b11000);
    set_instr(7'b0000011, 3'b010, 1'b0);
    fetch_decode("rst lw");
    step;
    chk("rst memread adr", 8'(AdrSrc), 8'd1);
    Reset = 1'b1;
    #1;
    chk("rst memread en", 8'(en), 8'b00000);
    step;
    chk("rst held en", 8'(en), 8'b00000);
    Reset = 1'b0;
    #1;
    chk("rst fetch en", 8'(en), 8'b11000);
    chk("rst fetch srcb", 8'(ALUSrcB), 8'b10);
    step;
    chk("rst decode en", 8'(en), 8'b00000);
    chk("rst decode srca", 8'(ALUSrcA), 8'b01);
`ifdef MC_MEM_WAIT_EN
    step;
    step;
    MemReady = 1'b0;
    #1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("wait%0d en", k), 8'(en), 8'b00000);
      step;
    end
    chk("timeout en", 8'(en), 8'b00001);
    step;
    MemReady = 1'b1;
    #1;
    chk("timeout fetch en", 8'(en), 8'b11000);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
